// File: rtl/mdu_mult_ctrl_if.sv
// Multiplier handshake bundle between the EX-stage sequencing controller
// (master) and the multi-cycle multiplier (slave).
//
// Handshake: the master raises mul_valid_o with mul_signed_o and both
// operands stable, and holds all four unchanged until it samples
// mul_ready_i high on a rising clk edge. mul_result_i is meaningful only in
// that cycle. The slave restarts its count whenever mul_valid_o is low, so
// dropping valid aborts an operation. mul_ready_i while valid is low carries
// no meaning and is ignored.
interface mdu_mult_ctrl_if #(
    parameter int DATA_LEN = 32
);
    logic                  mul_valid_o;
    logic                  mul_signed_o;
    logic [DATA_LEN-1:0]   mul_op1_o;
    logic [DATA_LEN-1:0]   mul_op2_o;
    logic                  mul_ready_i;
    logic [2*DATA_LEN-1:0] mul_result_i;

    modport master (
        output mul_valid_o,
        output mul_signed_o,
        output mul_op1_o,
        output mul_op2_o,
        input  mul_ready_i,
        input  mul_result_i
    );

    modport slave (
        input  mul_valid_o,
        input  mul_signed_o,
        input  mul_op1_o,
        input  mul_op2_o,
        output mul_ready_i,
        output mul_result_i
    );
endinterface

// File: rtl/mdu_mult_ctrl.sv
// EX-stage multiply sequencing controller. Latches a multiply-class
// instruction, runs the multiplier handshake while stalling the pipeline,
// folds the product into HI:LO for MADD/MSUB, and emits a single-cycle
// HI/LO or GPR writeback. A pipeline flush aborts at any point.
module mdu_mult_ctrl #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [2:0]          op_i,
    input  logic [DATA_LEN-1:0] opdata1_i,
    input  logic [DATA_LEN-1:0] opdata2_i,
    input  logic [DATA_LEN-1:0] hi_i,
    input  logic [DATA_LEN-1:0] lo_i,
    input  logic                flush_i,
    mdu_mult_ctrl_if.master     mul,
    output logic                stall_o,
    output logic                done_o,
    output logic                hilo_we_o,
    output logic [DATA_LEN-1:0] hi_o,
    output logic [DATA_LEN-1:0] lo_o,
    output logic                gpr_we_o,
    output logic [DATA_LEN-1:0] gpr_data_o,
    output logic [1:0]          dbg_state
);

    localparam int PW = 2 * DATA_LEN;

    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [2:0]          op_q;
    logic                signed_q;
    logic [DATA_LEN-1:0] op1_q;
    logic [DATA_LEN-1:0] op2_q;
    logic [PW-1:0]       hilo_q;
    // Holds the raw product after MUL, then the accumulated HI:LO after ACC.
    logic [PW-1:0]       res_q;

    logic                launch;
    logic                is_acc;
    logic                is_sub;

    logic                valid_c;
    logic                stall_c;
    logic                done_c;
    logic                hilo_we_c;
    logic                gpr_we_c;

    assign launch = start_i && (op_i != OP_RSV) && !flush_i;
    // 010/011 are MADD*, 100/101 are MSUB*.
    assign is_acc = (op_q[2:1] == 2'b01) || (op_q[2:1] == 2'b10);
    assign is_sub = (op_q[2:1] == 2'b10);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; flush wins over every other transition.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    state_next = ST_MUL;
                end
            end
            ST_MUL: begin
                if (flush_i) begin
                    state_next = ST_IDLE;
                end else if (mul.mul_ready_i) begin
                    state_next = is_acc ? ST_ACC : ST_DONE;
                end
            end
            ST_ACC: begin
                state_next = flush_i ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                // The instruction still sitting in EX is the one just
                // finished, so never relaunch from here.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand/HI:LO capture at launch, product capture, and accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= 3'b000;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            hilo_q   <= '0;
            res_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        op_q     <= op_i;
                        signed_q <= !op_i[0];
                        op1_q    <= opdata1_i;
                        op2_q    <= opdata2_i;
                        hilo_q   <= {hi_i, lo_i};
                    end
                end
                ST_MUL: begin
                    if (mul.mul_ready_i && !flush_i) begin
                        res_q <= mul.mul_result_i;
                    end
                end
                ST_ACC: begin
                    if (!flush_i) begin
                        res_q <= is_sub ? (hilo_q - res_q) : (hilo_q + res_q);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake, stall and writeback strobes; all held low during reset.
    always_comb begin
        valid_c   = 1'b0;
        stall_c   = 1'b0;
        done_c    = 1'b0;
        hilo_we_c = 1'b0;
        gpr_we_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                stall_c = launch;
            end
            ST_MUL: begin
                valid_c = 1'b1;
                stall_c = 1'b1;
            end
            ST_ACC: begin
                stall_c = 1'b1;
            end
            ST_DONE: begin
                if (!flush_i) begin
                    done_c    = 1'b1;
                    hilo_we_c = (op_q != OP_MUL);
                    gpr_we_c  = (op_q == OP_MUL);
                end
            end
            default: begin
            end
        endcase
        if (rst) begin
            valid_c   = 1'b0;
            stall_c   = 1'b0;
            done_c    = 1'b0;
            hilo_we_c = 1'b0;
            gpr_we_c  = 1'b0;
        end
    end

    assign mul.mul_valid_o  = valid_c;
    assign mul.mul_signed_o = signed_q;
    assign mul.mul_op1_o    = op1_q;
    assign mul.mul_op2_o    = op2_q;

    assign stall_o    = stall_c;
    assign done_o     = done_c;
    assign hilo_we_o  = hilo_we_c;
    assign gpr_we_o   = gpr_we_c;
    assign hi_o       = res_q[PW-1:DATA_LEN];
    assign lo_o       = res_q[DATA_LEN-1:0];
    assign gpr_data_o = res_q[DATA_LEN-1:0];
    assign dbg_state  = state;

endmodule

// File: doc/mdu_mult_ctrl.md
Name: mdu_mult_ctrl

Overview:
Sequencing controller for the EX-stage multi-cycle multiplier. Accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MUL requests from EX, holds the pipeline stalled while driving the multiplier valid/ready handshake, and performs the MADD/MSUB HI/LO accumulate. Presents a one-cycle HI/LO or GPR writeback when the operation completes, and honours pipeline flush.

Parameters:
DATA_LEN, 32, operand width; the product and HI:LO are 2*DATA_LEN.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start_i  in  1  EX holds a multiply-class instruction; stays high while stall_o is high
op_i  in  3  000 MULT, 001 MULTU, 010 MADD, 011 MADDU, 100 MSUB, 101 MSUBU, 110 MUL, 111 reserved
opdata1_i  in  DATA_LEN  rs operand
opdata2_i  in  DATA_LEN  rt operand
hi_i  in  DATA_LEN  current HI, forwarded value
lo_i  in  DATA_LEN  current LO, forwarded value
flush_i  in  1  pipeline flush; aborts any operation
mul_valid_o  out  1  multiplier enable; held high until mul_ready_i
mul_signed_o  out  1  signed multiply select
mul_op1_o  out  DATA_LEN  latched operand 1
mul_op2_o  out  DATA_LEN  latched operand 2
mul_ready_i  in  1  multiplier result valid
mul_result_i  in  2*DATA_LEN  signed/unsigned product per mul_signed_o
stall_o  out  1  stall request to pipeline control
done_o  out  1  one-cycle completion pulse
hilo_we_o  out  1  HI/LO write enable, valid with done_o
hi_o  out  DATA_LEN  HI write data
lo_o  out  DATA_LEN  LO write data
gpr_we_o  out  1  GPR write enable (MUL only), valid with done_o
gpr_data_o  out  DATA_LEN  low DATA_LEN bits of the product

Behaviour:
- States: IDLE, MUL, ACC, DONE. On reset: state IDLE; all registered outputs and latches 0. mul_valid_o, stall_o, done_o, hilo_we_o and gpr_we_o are 0 during reset.
- IDLE: if start_i && op_i!=111 && !flush_i: latch op, operands, hi_i/lo_i; set signed = !op_i[0] (MUL is signed); go to MUL. Reserved op: ignored, no stall.
- MUL: mul_valid_o=1 and operands stable. When mul_ready_i=1, latch mul_result_i; go to ACC for MADD*/MSUB*, otherwise go to DONE.
- ACC: 64-bit {HI,LO} + product (MADD*) or {HI,LO} - product (MSUB*), modulo 2^(2*DATA_LEN), computed with the HI/LO latched at start. Go to DONE.
- DONE: mul_valid_o=0, stall_o=0, done_o=1. MULT*/MADD*/MSUB*: hilo_we_o=1 with hi_o/lo_o. MUL: gpr_we_o=1, gpr_data_o=product[DATA_LEN-1:0], HI/LO untouched. Always returns to IDLE; start_i in DONE is the same instruction and is not restarted.
- stall_o (combinational) = (IDLE && start_i && legal op && !flush_i) || MUL || ACC.
- Latency: if the multiplier asserts ready L cycles after valid rises, MULT/MUL stall for L+1 cycles and MADD/MSUB stall for L+2 cycles; done follows in the next cycle.
- flush_i: has priority in every state. The next state is IDLE and mul_valid_o drops, which resets the multiplier counter. In DONE, flush_i gates done_o, hilo_we_o and gpr_we_o to 0 combinationally. A flush in IDLE together with start_i does not start an operation.
- rst mid-operation: IDLE next cycle; no writeback.
- mul_ready_i outside MUL: ignored.
- Operand changes on opdata*_i after launch: ignored, because the operands are latched.

Test Plan:
- MULT -2*3: op=000, op1=0xFFFFFFFE, op2=3, mock multiplier with ready on the 6th valid cycle -> stall_o high 7 cycles, mul_signed_o=1, then done_o with hilo_we_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, gpr_we_o=0.
- MADDU carry: hi_i=0, lo_i=0xFFFFFFFF, op=011, 1*1 -> one extra ACC cycle; hi_o=0x00000001, lo_o=0x00000000; mul_signed_o=0.
- MSUB wrap: hi_i=0, lo_i=0, op=100, 1*1 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFF.
- MUL: op=110, 0x00010003*0x00010000 -> gpr_we_o=1, gpr_data_o=0x00030000, hilo_we_o=0.
- Flush mid-MUL: assert flush_i on the 3rd valid cycle -> next cycle IDLE, mul_valid_o=0, stall_o=0, no done_o. A new MULT 2*2 issued afterwards -> lo_o=4 after a full latency.
- Reserved op / reset: op=111 with start_i -> stall_o=0, no mul_valid_o. rst during ACC -> IDLE, all outputs 0, no writeback.
